// File: rtl/hazard_ctl.sv
// Stall/flush/forwarding controller and mult/div busy sequencer for the 5-stage MIPS core.
// Define HAZARD_PERF_CNT_EN to add the saturating PerfStallCnt/PerfFlushCnt/PerfMulDivCnt ports.
module hazard_ctl #(
  parameter int MULDIV_LAT = 8,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic       UsesRs_ID,
  input  logic       UsesRt_ID,
  input  logic       UsesHiLo_ID,
  input  logic [4:0] Rs_EX,
  input  logic [4:0] Rt_EX,
  input  logic [4:0] WriteReg_EX,
  input  logic [4:0] WriteReg_MEM,
  input  logic [4:0] WriteReg_WB,
  input  logic       RegWrite_EX,
  input  logic       RegWrite_MEM,
  input  logic       RegWrite_WB,
  input  logic       MemToReg_EX,
  input  logic       MulDivStart_EX,
  input  logic       BranchTaken_EX,
  input  logic       ImemReady_IF,
  output logic       Stall_IF,
  output logic       Stall_ID,
  output logic       Flush_ID,
  output logic       Flush_EX,
  output logic [1:0] FwdA_EX,
  output logic [1:0] FwdB_EX,
  output logic       MulDivBusy,
  output logic       MulDivDone
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] PerfStallCnt,
  output logic [CNT_W-1:0] PerfFlushCnt,
  output logic [CNT_W-1:0] PerfMulDivCnt
`endif
);

  if (MULDIV_LAT < 2 || MULDIV_LAT > 31 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctl: MULDIV_LAT must be 2..31 and CNT_W at least 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] LAT_M1 = 5'(MULDIV_LAT - 1);

  md_state_e  md_state_r;
  logic [4:0] md_cnt_r;
  logic       hold_r;
  logic       load_use_s;
  logic       hilo_s;
  logic       imem_miss_s;

  // MEM holds the younger result, so it wins over WB; $0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_wr,
    input logic [4:0] mem_rd,
    input logic       wb_wr,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    if (mem_wr && (mem_rd != 5'd0) && (mem_rd == src)) begin
      sel = 2'b10;
    end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign load_use_s = MemToReg_EX && RegWrite_EX && (WriteReg_EX != 5'd0) &&
                      ((UsesRs_ID && (Rs_ID == WriteReg_EX)) ||
                       (UsesRt_ID && (Rt_ID == WriteReg_EX)));
  assign hilo_s      = MulDivBusy && UsesHiLo_ID;
  assign imem_miss_s = !ImemReady_IF;

  // Set by reset and held until the first clock after release, forcing the bubble state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_r <= 1'b1;
    end else begin
      hold_r <= 1'b0;
    end
  end

  // Mult/div busy FSM: counts MULDIV_LAT-1 down to 0, Done registered one edge ahead of the last cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_state_r <= IDLE;
      md_cnt_r   <= 5'd0;
      MulDivBusy <= 1'b0;
      MulDivDone <= 1'b0;
    end else begin
      case (md_state_r)
        IDLE: begin
          MulDivDone <= 1'b0;
          if (MulDivStart_EX) begin
            md_state_r <= BUSY;
            md_cnt_r   <= LAT_M1;
            MulDivBusy <= 1'b1;
          end else begin
            md_state_r <= IDLE;
            md_cnt_r   <= 5'd0;
            MulDivBusy <= 1'b0;
          end
        end
        BUSY: begin
          if (md_cnt_r == 5'd0) begin
            md_state_r <= IDLE;
            MulDivBusy <= 1'b0;
            MulDivDone <= 1'b0;
          end else begin
            md_state_r <= BUSY;
            md_cnt_r   <= md_cnt_r - 5'd1;
            MulDivBusy <= 1'b1;
            MulDivDone <= (md_cnt_r == 5'd1);
          end
        end
        default: begin
          md_state_r <= IDLE;
          md_cnt_r   <= 5'd0;
          MulDivBusy <= 1'b0;
          MulDivDone <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A second issue while busy is dropped by the FSM; make it visible in simulation.
  always @(posedge clk) begin
    if (!reset && MulDivStart_EX && (md_state_r == BUSY)) begin
      $display("hazard_ctl: MulDivStart_EX while busy ignored at %0t", $time);
    end
  end
`endif

  // Redirect beats every stall because the held ID instruction is wrong-path.
  always_comb begin
    Stall_IF = 1'b0;
    Stall_ID = 1'b0;
    Flush_ID = 1'b0;
    Flush_EX = 1'b0;
    FwdA_EX  = 2'b00;
    FwdB_EX  = 2'b00;
    if (hold_r) begin
      Flush_ID = 1'b1;
      Flush_EX = 1'b1;
    end else begin
      FwdA_EX = fwd_sel(Rs_EX, RegWrite_MEM, WriteReg_MEM, RegWrite_WB, WriteReg_WB);
      FwdB_EX = fwd_sel(Rt_EX, RegWrite_MEM, WriteReg_MEM, RegWrite_WB, WriteReg_WB);
      if (BranchTaken_EX) begin
        Flush_ID = 1'b1;
        Flush_EX = 1'b1;
      end else if (load_use_s || hilo_s) begin
        Stall_IF = 1'b1;
        Stall_ID = 1'b1;
        Flush_EX = 1'b1;
      end else if (imem_miss_s) begin
        Stall_IF = 1'b1;
        Flush_ID = 1'b1;
      end else begin
        Stall_IF = 1'b0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
    logic [CNT_W-1:0] res;
    if (en && (val != {CNT_W{1'b1}})) begin
      res = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Event counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PerfStallCnt  <= {CNT_W{1'b0}};
      PerfFlushCnt  <= {CNT_W{1'b0}};
      PerfMulDivCnt <= {CNT_W{1'b0}};
    end else begin
      PerfStallCnt  <= sat_inc(PerfStallCnt, Stall_ID);
      PerfFlushCnt  <= sat_inc(PerfFlushCnt, BranchTaken_EX);
      PerfMulDivCnt <= sat_inc(PerfMulDivCnt, md_state_r == BUSY);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed cases with literal expectations plus random
// stimulus compared every cycle against a cycle-indexed behavioural model.
module tb_hazard_ctl;
  localparam int LAT = 8;
  localparam int CW  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] Rs_ID, Rt_ID, Rs_EX, Rt_EX, WriteReg_EX, WriteReg_MEM, WriteReg_WB;
  logic       UsesRs_ID, UsesRt_ID, UsesHiLo_ID, RegWrite_EX, RegWrite_MEM, RegWrite_WB;
  logic       MemToReg_EX, MulDivStart_EX, BranchTaken_EX, ImemReady_IF;
  logic       Stall_IF, Stall_ID, Flush_ID, Flush_EX, MulDivBusy, MulDivDone;
  logic [1:0] FwdA_EX, FwdB_EX;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] PerfStallCnt, PerfFlushCnt, PerfMulDivCnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
    .UsesHiLo_ID(UsesHiLo_ID), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX),
    .WriteReg_EX(WriteReg_EX), .WriteReg_MEM(WriteReg_MEM), .WriteReg_WB(WriteReg_WB),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .MemToReg_EX(MemToReg_EX), .MulDivStart_EX(MulDivStart_EX),
    .BranchTaken_EX(BranchTaken_EX), .ImemReady_IF(ImemReady_IF),
    .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Flush_ID(Flush_ID), .Flush_EX(Flush_EX),
    .FwdA_EX(FwdA_EX), .FwdB_EX(FwdB_EX), .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone)
`ifdef HAZARD_PERF_CNT_EN
    , .PerfStallCnt(PerfStallCnt), .PerfFlushCnt(PerfFlushCnt), .PerfMulDivCnt(PerfMulDivCnt)
`endif
  );

  // Model: cycle index, post-reset hold flag, and the cycle a mult/div was accepted.
  int cyc = 0;
  bit m_hold = 1'b1;
  bit m_valid = 1'b0;
  int m_n = 0;

  function automatic bit m_busy(input int c);
    return m_valid && (c > m_n) && (c <= m_n + LAT);
  endfunction

  function automatic bit m_done(input int c);
    return m_valid && (c == m_n + LAT);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    logic       wr  [2];
    logic [4:0] rd  [2];
    logic [1:0] code[2];
    wr[0] = RegWrite_MEM; rd[0] = WriteReg_MEM; code[0] = 2'b10;
    wr[1] = RegWrite_WB;  rd[1] = WriteReg_WB;  code[1] = 2'b01;
    for (int s = 0; s < 2; s++) begin
      if (wr[s] && rd[s] != 5'd0 && rd[s] == src) return code[s];
    end
    return 2'b00;
  endfunction

  // Returns {Stall_IF, Stall_ID, Flush_ID, Flush_EX}.
  function automatic logic [3:0] m_ctl();
    logic lu, hl;
    lu = MemToReg_EX && RegWrite_EX && WriteReg_EX != 5'd0 &&
         ((UsesRs_ID && Rs_ID == WriteReg_EX) || (UsesRt_ID && Rt_ID == WriteReg_EX));
    hl = m_busy(cyc) && UsesHiLo_ID;
    if (reset || m_hold) return 4'b0011;
    if (BranchTaken_EX) return 4'b0011;
    if (lu || hl) return 4'b1101;
    if (!ImemReady_IF) return 4'b1010;
    return 4'b0000;
  endfunction

  function automatic bit m_stall_id();
    logic [3:0] v;
    v = m_ctl();
    return v[2];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hold  <= 1'b1;
      m_valid <= 1'b0;
    end else begin
      m_hold <= 1'b0;
      if (MulDivStart_EX && !m_busy(cyc)) begin
        m_valid <= 1'b1;
        m_n     <= cyc;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] m_pstall = '0, m_pflush = '0, m_pmd = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pstall <= '0; m_pflush <= '0; m_pmd <= '0;
    end else begin
      if (m_stall_id() && m_pstall != '1) m_pstall <= m_pstall + 1'b1;
      if (BranchTaken_EX && m_pflush != '1) m_pflush <= m_pflush + 1'b1;
      if (m_busy(cyc) && m_pmd != '1) m_pmd <= m_pmd + 1'b1;
    end
  end
`endif

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0] e;
    logic       fwd_ok;
    e = m_ctl();
    fwd_ok = !(reset || m_hold);
    chk1("stall_if", Stall_IF, e[3]);
    chk1("stall_id", Stall_ID, e[2]);
    chk1("flush_id", Flush_ID, e[1]);
    chk1("flush_ex", Flush_EX, e[0]);
    chk2("fwd_a", FwdA_EX, fwd_ok ? m_fwd(Rs_EX) : 2'b00);
    chk2("fwd_b", FwdB_EX, fwd_ok ? m_fwd(Rt_EX) : 2'b00);
    chk1("muldiv_busy", MulDivBusy, m_busy(cyc));
    chk1("muldiv_done", MulDivDone, m_done(cyc));
`ifdef HAZARD_PERF_CNT_EN
    chkw("perf_stall", PerfStallCnt, m_pstall);
    chkw("perf_flush", PerfFlushCnt, m_pflush);
    chkw("perf_muldiv", PerfMulDivCnt, m_pmd);
`endif
  endtask

  task automatic neutral();
    Rs_ID = 5'd0; Rt_ID = 5'd0; Rs_EX = 5'd0; Rt_EX = 5'd0;
    WriteReg_EX = 5'd0; WriteReg_MEM = 5'd0; WriteReg_WB = 5'd0;
    UsesRs_ID = 1'b0; UsesRt_ID = 1'b0; UsesHiLo_ID = 1'b0;
    RegWrite_EX = 1'b0; RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0;
    MemToReg_EX = 1'b0; MulDivStart_EX = 1'b0; BranchTaken_EX = 1'b0; ImemReady_IF = 1'b1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    neutral();
  endtask

  task automatic sample();
    #2;
    check_all();
  endtask

  task automatic set_load_use();
    MemToReg_EX = 1'b1; RegWrite_EX = 1'b1; WriteReg_EX = 5'd8;
    UsesRt_ID = 1'b1; Rt_ID = 5'd8;
  endtask

  initial begin
    neutral();
    reset = 1'b1;
    @(negedge clk);
    sample();
    chk1("rst_stall_if", Stall_IF, 1'b0);
    chk1("rst_flush_id", Flush_ID, 1'b1);
    chk1("rst_flush_ex", Flush_EX, 1'b1);
    chk1("rst_busy", MulDivBusy, 1'b0);
    next_cycle();
    reset = 1'b0;
    sample();
    chk1("hold_flush_ex", Flush_EX, 1'b1);
    next_cycle(); sample();
    chk1("post_rst_flush_ex", Flush_EX, 1'b0);

    // Forwarding priority.
    next_cycle();
    WriteReg_MEM = 5'd5; WriteReg_WB = 5'd5; RegWrite_MEM = 1'b1; RegWrite_WB = 1'b1; Rs_EX = 5'd5;
    sample(); chk2("fwd_mem_wins", FwdA_EX, 2'b10);
    next_cycle();
    WriteReg_MEM = 5'd5; WriteReg_WB = 5'd5; RegWrite_WB = 1'b1; Rs_EX = 5'd5;
    sample(); chk2("fwd_wb", FwdA_EX, 2'b01);
    next_cycle();
    RegWrite_MEM = 1'b1; RegWrite_WB = 1'b1; Rs_EX = 5'd0; Rt_EX = 5'd0;
    sample(); chk2("fwd_r0_a", FwdA_EX, 2'b00); chk2("fwd_r0_b", FwdB_EX, 2'b00);

    // Load-use: one bubble, then the load sits in MEM and forwards.
    next_cycle(); set_load_use(); sample();
    chk1("lu_stall_if", Stall_IF, 1'b1); chk1("lu_stall_id", Stall_ID, 1'b1);
    chk1("lu_flush_ex", Flush_EX, 1'b1); chk1("lu_flush_id", Flush_ID, 1'b0);
    next_cycle(); RegWrite_MEM = 1'b1; WriteReg_MEM = 5'd8; Rt_EX = 5'd8; UsesRt_ID = 1'b1; Rt_ID = 5'd8;
    sample(); chk1("lu_released", Stall_ID, 1'b0); chk2("lu_fwd_mem", FwdB_EX, 2'b10);
    next_cycle(); set_load_use(); UsesRt_ID = 1'b0; sample();
    chk1("lu_unused_rt", Stall_ID, 1'b0);

    // Redirect during load-use.
    next_cycle(); set_load_use(); BranchTaken_EX = 1'b1; sample();
    chk1("redir_flush_id", Flush_ID, 1'b1); chk1("redir_flush_ex", Flush_EX, 1'b1);
    chk1("redir_stall_if", Stall_IF, 1'b0); chk1("redir_stall_id", Stall_ID, 1'b0);

    // Mult/div window with HI/LO consumer waiting in ID.
    next_cycle(); MulDivStart_EX = 1'b1; sample(); chk1("md_idle_at_start", MulDivBusy, 1'b0);
    for (int i = 1; i <= LAT + 1; i++) begin
      next_cycle(); UsesHiLo_ID = 1'b1; sample();
      chk1("md_busy_win", MulDivBusy, i <= LAT);
      chk1("md_done_win", MulDivDone, i == LAT);
      chk1("md_hl_stall", Stall_ID, i <= LAT);
    end

    // Imem miss for three cycles.
    for (int i = 0; i < 4; i++) begin
      next_cycle(); ImemReady_IF = (i == 3); sample();
      chk1("im_stall_if", Stall_IF, i < 3); chk1("im_flush_id", Flush_ID, i < 3);
    end
    next_cycle(); MulDivStart_EX = 1'b1; sample();
    next_cycle(); UsesHiLo_ID = 1'b1; ImemReady_IF = 1'b0; sample();
    chk1("im_hl_stall_id", Stall_ID, 1'b1); chk1("im_hl_flush_id", Flush_ID, 1'b0);
    chk1("im_hl_stall_if", Stall_IF, 1'b1);
    for (int i = 0; i < LAT + 2; i++) begin
      next_cycle(); sample();
    end

    // Reset in the third busy cycle.
    next_cycle(); MulDivStart_EX = 1'b1; sample();
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); sample();
    end
    #1 reset = 1'b1;
    #1;
    chk1("rst_mid_busy", MulDivBusy, 1'b0); chk1("rst_mid_done", MulDivDone, 1'b0);
    chk1("rst_mid_flush_id", Flush_ID, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
    chkw("rst_perf_stall", PerfStallCnt, '0); chkw("rst_perf_flush", PerfFlushCnt, '0);
    chkw("rst_perf_md", PerfMulDivCnt, '0);
`endif
    next_cycle(); reset = 1'b0; sample();
    for (int i = 0; i < LAT + 1; i++) begin
      next_cycle(); sample(); chk1("no_done_after_rst", MulDivDone, 1'b0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      next_cycle();
      Rs_ID = 5'($urandom_range(0, 3)); Rt_ID = 5'($urandom_range(0, 3));
      Rs_EX = 5'($urandom_range(0, 3)); Rt_EX = 5'($urandom_range(0, 3));
      WriteReg_EX = 5'($urandom_range(0, 3)); WriteReg_MEM = 5'($urandom_range(0, 3));
      WriteReg_WB = 5'($urandom_range(0, 3));
      UsesRs_ID = 1'($urandom_range(0, 1)); UsesRt_ID = 1'($urandom_range(0, 1));
      UsesHiLo_ID = 1'($urandom_range(0, 1));
      RegWrite_EX = 1'($urandom_range(0, 1)); RegWrite_MEM = 1'($urandom_range(0, 1));
      RegWrite_WB = 1'($urandom_range(0, 1)); MemToReg_EX = ($urandom_range(0, 2) == 0);
      BranchTaken_EX = ($urandom_range(0, 9) == 0); ImemReady_IF = ($urandom_range(0, 4) != 0);
      MulDivStart_EX = !m_busy(cyc) && ($urandom_range(0, 5) == 0);
      sample();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipelined MIPS core (IF, ID, EX, MEM, WB).
- Replaces the core's constant-zero stall tie-off.
- Drives the IF/ID stall enables, ID/EX bubble insertion and EX-stage operand forwarding selects.
- Sequences the multi-cycle multiply/divide unit through an internal busy FSM.

Parameters:
- MULDIV_LAT, 8, cycles the mult/div unit stays busy after issue; legal range 2..31.
- CNT_W, 16, width of each perf counter; only used when HAZARD_PERF_CNT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Rs_ID, Rt_ID  in  5 each  source register numbers of the instruction in ID.
- UsesRs_ID, UsesRt_ID  in  1 each  ID instruction actually reads Rs / Rt.
- UsesHiLo_ID  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- Rs_EX, Rt_EX  in  5 each  source registers of the instruction in EX.
- WriteReg_EX, WriteReg_MEM, WriteReg_WB  in  5 each  destination register per stage.
- RegWrite_EX, RegWrite_MEM, RegWrite_WB  in  1 each  stage writes the register file.
- MemToReg_EX  in  1  EX instruction is a load.
- MulDivStart_EX  in  1  mult/div in EX is issuing this cycle.
- BranchTaken_EX  in  1  taken branch/redirect resolved in EX.
- ImemReady_IF  in  1  fetch data valid this cycle.
- Stall_IF  out  1  hold the PC.
- Stall_ID  out  1  hold the IF/ID register.
- Flush_ID  out  1  load a bubble into IF/ID.
- Flush_EX  out  1  load a bubble into ID/EX.
- FwdA_EX, FwdB_EX  out  2 each  operand select: 00 regfile, 01 WB result, 10 MEM result.
- MulDivBusy  out  1  mult/div unit busy (registered).
- MulDivDone  out  1  one-cycle pulse on the last busy cycle (registered).

Behaviour:
- Forwarding is combinational.
  - FwdA_EX = 10 if RegWrite_MEM and WriteReg_MEM != 0 and WriteReg_MEM == Rs_EX.
  - Otherwise 01 if the same conditions hold for WB.
  - Otherwise 00.
  - FwdB_EX uses the same rules with Rt_EX.
  - MEM beats WB. Register $0 is never forwarded.
- Load-use (combinational): LU = MemToReg_EX & RegWrite_EX & WriteReg_EX != 0 & ((UsesRs_ID & Rs_ID == WriteReg_EX) | (UsesRt_ID & Rt_ID == WriteReg_EX)).
  - Exactly one bubble. The next cycle the load is in MEM and is covered by forwarding.
- Mult/div FSM: states IDLE and BUSY, plus a down-counter of width 5.
  - IDLE -> BUSY on MulDivStart_EX; the counter loads MULDIV_LAT-1.
  - In BUSY the counter decrements each cycle.
  - When the counter is 0, MulDivDone pulses for one cycle and the FSM returns to IDLE.
  - MulDivBusy = (state == BUSY). Busy therefore lasts exactly MULDIV_LAT cycles after the start edge.
  - MulDivStart_EX while BUSY is a protocol violation: ignored, and flagged by a simulation-only $display.
  - HL = MulDivBusy & UsesHiLo_ID.
- IM = ~ImemReady_IF.
- Output priority, highest first:
  - BranchTaken_EX: Flush_ID = 1, Flush_EX = 1, Stall_IF = 0, Stall_ID = 0. A redirect overrides any stall, because the stalled ID instruction is wrong-path.
  - LU or HL: Stall_IF = 1, Stall_ID = 1, Flush_EX = 1, Flush_ID = 0.
  - IM: Stall_IF = 1, Flush_ID = 1. Stall_ID = 0 and Flush_EX = 0 unless set by another rule.
  - Otherwise: all four outputs 0.
- Redirect does not abort the mult/div FSM; the issuing instruction is older than the branch.
- While reset is asserted, and from reset until the first clock:
  - Stall_IF = 0, Stall_ID = 0, Flush_ID = 1, Flush_EX = 1.
  - FwdA_EX = FwdB_EX = 00.
  - FSM in IDLE, counter 0, MulDivBusy = 0, MulDivDone = 0.
- Reset mid-BUSY returns the FSM to IDLE immediately, asynchronously.
- Latency: all stall/flush/forward outputs are same-cycle combinational from their inputs. MulDivBusy and MulDivDone are registered.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds three saturating CNT_W-bit output ports, all reset to 0 and saturating at all-ones:
  - PerfStallCnt: cycles with Stall_ID = 1.
  - PerfFlushCnt: cycles with BranchTaken_EX = 1.
  - PerfMulDivCnt: BUSY cycles.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Forwarding priority: WriteReg_MEM = WriteReg_WB = 5, both RegWrite = 1, Rs_EX = 5 -> FwdA_EX = 10. Drop RegWrite_MEM -> 01. Set both WriteReg to 0 -> 00.
- Load-use: MemToReg_EX = 1, WriteReg_EX = 8, UsesRt_ID = 1, Rt_ID = 8 -> Stall_IF = Stall_ID = Flush_EX = 1 for exactly 1 cycle. Same case with UsesRt_ID = 0 -> no stall.
- Mult/div: pulse MulDivStart_EX at cycle N with MULDIV_LAT = 8 -> MulDivBusy high for cycles N+1..N+8, MulDivDone high only in N+8. UsesHiLo_ID held high -> stall over the same window, released at N+9.
- Redirect during a load-use stall: LU true and BranchTaken_EX = 1 -> Flush_ID = Flush_EX = 1, Stall_IF = Stall_ID = 0.
- Imem miss: ImemReady_IF = 0 for 3 cycles -> Stall_IF = 1 and Flush_ID = 1 for those 3 cycles only. Add HL during the miss -> Stall_ID = 1, Flush_ID = 0.
- Reset at cycle 3 of BUSY -> MulDivBusy = 0 immediately, no MulDivDone pulse. With HAZARD_PERF_CNT_EN defined, all counters read 0.
